cop0_commit_pipe: RTL

Carries coprocessor-0 writes produced in execute through the memory and writeback stages and commits them into the architectural CP0 registers Status, Cause, EPC, Count and Compare. Also provides:
- A forwarded Status value back to execute, for interrupt checks.
- The Count/Compare timer.
- Hardware-interrupt sampling into Cause.
- Exception side effects on Cause and EPC.

---
 rtl/cop0_commit_pipe_pkg.sv | 25 ++
 rtl/selector.sv | 13 +
 rtl/cop0_count_timer.sv | 62 ++++++
 rtl/cop0_commit_pipe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cop0_commit_pipe_pkg.sv
// Shared CP0 constants, Cause/Status field positions and the pipeline entry type.
package cop0_commit_pipe_pkg;

  localparam logic [31:0] COP0_STATUS_RESET = 32'h0040_0004;  // BEV = 1, ERL = 1
  localparam logic [31:0] COP0_CAUSE_WMASK  = 32'h0000_0300;  // IP1:0 only

  // Status field positions
  localparam int STATUS_EXL = 1;

  // Cause field positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_IP_HW_H = 15;
  localparam int CAUSE_IP_HW_L = 10;
  localparam int CAUSE_EXC_H   = 6;
  localparam int CAUSE_EXC_L   = 2;

  // One in-flight CP0 write; valid already folds in the write request.
  typedef struct packed {
    logic                    valid;
    selector::destnation_cop0 dest;
    logic [31:0]             data;
  } cop0_stage_t;

endpackage

// File: rtl/selector.sv
// Destination-register selector shared by the decode and CP0 commit paths.
package selector;

  typedef enum logic [2:0] {
    COP0_NONE    = 3'd0,
    COP0_STATUS  = 3'd1,
    COP0_CAUSE   = 3'd2,
    COP0_EPC     = 3'd3,
    COP0_COUNT   = 3'd4,
    COP0_COMPARE = 3'd5
  } destnation_cop0;

endpackage

// File: rtl/cop0_count_timer.sv
// Count/Compare timer: clock divider, Count, Compare and the timer interrupt.
module cop0_count_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase_q;
  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic          timer_int_q;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (phase_q == PHASE_LAST);
  assign count_inc = count_q + 32'd1;  // wraps 0xFFFF_FFFF -> 0

  // Divider phase and Count: a software load wins over the increment and restarts the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      phase_q <= '0;
      count_q <= '0;
    end else if (count_we) begin
      phase_q <= '0;
      count_q <= wdata;
    end else if (tick) begin
      phase_q <= '0;
      count_q <= count_inc;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

  // Compare and timer_int: a Compare write clears the interrupt, a matching increment raises it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else if (compare_we) begin
      compare_q   <= wdata;
      timer_int_q <= 1'b0;
    end else if (!count_we && tick && (count_inc == compare_q)) begin
      timer_int_q <= 1'b1;
    end
  end

  assign count     = count_q;
  assign compare   = compare_q;
  assign timer_int = timer_int_q;

endmodule

// File: rtl/cop0_commit_pipe.sv
// CP0 write pipeline (M, W) with commit into Status/Cause/EPC/Count/Compare,
// Status forwarding to execute, exception side effects and interrupt sampling.
module cop0_commit_pipe
  import cop0_commit_pipe_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ex_valid,
  input  logic                     ex_write,
  input  selector::destnation_cop0 ex_dest,
  input  logic [31:0]              ex_data,
  input  logic                     stall,
  input  logic                     flush_mem,
  input  logic                     exc_valid,
  input  logic [4:0]               exc_code,
  input  logic [31:0]              exc_epc,
  input  logic                     exc_bd,
  input  logic [5:0]               hw_int,
  output logic [31:0]              status_fwd,
  output logic [31:0]              status,
  output logic [31:0]              cause,
  output logic [31:0]              epc,
  output logic [31:0]              count,
  output logic [31:0]              compare,
  output logic                     timer_int
);

  cop0_stage_t m_q;
  cop0_stage_t w_q;

  logic [31:0] status_q;
  logic [31:0] cause_q;   // TI is not stored; it is merged from timer_int on output
  logic [31:0] cause_d;
  logic [31:0] epc_q;

  logic commit;
  logic commit_status;
  logic commit_cause;
  logic commit_epc;
  logic commit_count;
  logic commit_compare;
  logic exc_sets_epc;

  assign commit         = !stall && w_q.valid;
  assign commit_status  = commit && (w_q.dest == selector::COP0_STATUS);
  assign commit_cause   = commit && (w_q.dest == selector::COP0_CAUSE);
  assign commit_epc     = commit && (w_q.dest == selector::COP0_EPC);
  assign commit_count   = commit && (w_q.dest == selector::COP0_COUNT);
  assign commit_compare = commit && (w_q.dest == selector::COP0_COMPARE);

  // EPC and BD are only captured for the first exception (EXL clear).
  assign exc_sets_epc   = exc_valid && !status_q[STATUS_EXL];

  // M and W stage registers: advance when not stalled; flush kills the M entry even under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      w_q <= '0;
    end else if (!stall) begin
      w_q.valid <= m_q.valid && !flush_mem;
      w_q.dest  <= m_q.dest;
      w_q.data  <= m_q.data;
      m_q.valid <= ex_valid && ex_write && !flush_mem;
      m_q.dest  <= ex_dest;
      m_q.data  <= ex_data;
    end else if (flush_mem) begin
      m_q.valid <= 1'b0;
    end
  end

  // Status register commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= COP0_STATUS_RESET;
    end else if (commit_status) begin
      status_q <= w_q.data;
    end
  end

  // EPC: a capturing exception overrides a same-edge committed write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_q <= '0;
    end else if (exc_sets_epc) begin
      epc_q <= exc_epc;
    end else if (commit_epc) begin
      epc_q <= w_q.data;
    end
  end

  // Next Cause: hardware IP sampled every edge, software IP from commit, exception fields last.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    cause_d = cause_q;
    cause_d[CAUSE_IP_HW_H:CAUSE_IP_HW_L] = hw_int;
    if (commit_cause) begin
      cause_d = (cause_d & ~COP0_CAUSE_WMASK) | (w_q.data & COP0_CAUSE_WMASK);
    end
    if (exc_valid) begin
      cause_d[CAUSE_EXC_H:CAUSE_EXC_L] = exc_code;
      if (!status_q[STATUS_EXL]) begin
        cause_d[CAUSE_BD] = exc_bd;
      end
    end
    cause_d[CAUSE_TI] = 1'b0;
  end

  // Cause register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_d;
    end
  end

  // Status as execute must see it: youngest in-flight Status write wins.
  always_comb begin
    status_fwd = status_q;
    if (m_q.valid && (m_q.dest == selector::COP0_STATUS)) begin
      status_fwd = m_q.data;
    end else if (w_q.valid && (w_q.dest == selector::COP0_STATUS)) begin
      status_fwd = w_q.data;
    end
  end

  cop0_count_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_count_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_we   (commit_count),
    .compare_we (commit_compare),
    .wdata      (w_q.data),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  // Architectural outputs; TI mirrors the timer interrupt.
  always_comb begin
    cause           = cause_q;
    cause[CAUSE_TI] = timer_int;
  end

  assign status = status_q;
  assign epc    = epc_q;

endmodule
